// File: rtl/serial_parity_pkg.sv
// serial_parity_pkg: shared FSM encoding and line levels for the serial parity receiver
package serial_parity_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
endpackage

// File: rtl/word_comparator.sv
// word_comparator: unsigned magnitude compare of two W-bit words
//   a_i, b_i : operands
//   gt_o     : a_i >  b_i
//   eq_o     : a_i == b_i
//   lt_o     : a_i <  b_i
module word_comparator #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         gt_o,
    output logic         eq_o,
    output logic         lt_o
);
    assign gt_o = a_i > b_i;
    assign eq_o = a_i == b_i;
    assign lt_o = a_i < b_i;
endmodule

// File: rtl/serial_parity_receiver.sv
// serial_parity_receiver: start/data(LSB first)/parity/stop frame receiver with parity check and word compare
//   clk        : clock
//   rst_n      : synchronous active-low reset
//   bit_en     : sample strobe, sin consumed only when high
//   sin        : serial line, idles high
//   ref_word   : comparison operand, sampled with the stop bit
//   data_out   : last accepted word
//   data_valid : one-cycle pulse, frame accepted
//   parity_err : one-cycle pulse with data_valid, parity mismatch
//   frame_err  : one-cycle pulse, stop bit was 0
//   gt/eq/lt   : data_out vs ref_word at acceptance (unsigned)
//   busy       : receiver is inside a frame
module serial_parity_receiver
    import serial_parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              sin,
    input  logic [DATA_W-1:0] ref_word,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              gt,
    output logic              eq,
    output logic              lt,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W + 1);
    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] data_q;
    logic              par_q;
    logic              valid_q;
    logic              perr_q;
    logic              ferr_q;
    logic              gt_q;
    logic              eq_q;
    logic              lt_q;
    logic              cmp_gt;
    logic              cmp_eq;
    logic              cmp_lt;
    word_comparator #(.W(DATA_W)) u_cmp (
        .a_i  (shift_q),
        .b_i  (ref_word),
        .gt_o (cmp_gt),
        .eq_o (cmp_eq),
        .lt_o (cmp_lt)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            // pulses last exactly one clk regardless of strobe spacing
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            if (bit_en) begin
                case (state_q)
                    ST_IDLE: begin
                        if (sin == START_LEVEL) begin
                            state_q <= ST_DATA;
                            cnt_q   <= '0;
                        end
                    end
                    ST_DATA: begin
                        // LSB arrives first, so after DATA_W shifts it sits at bit 0
                        shift_q <= {sin, shift_q[DATA_W-1:1]};
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == CW'(DATA_W - 1))
                            state_q <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_q   <= sin;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        // a low stop bit is a framing error, never a new start
                        if (sin == IDLE_LEVEL) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            perr_q  <= ^shift_q ^ par_q ^ PARITY_ODD;
                            gt_q    <= cmp_gt;
                            eq_q    <= cmp_eq;
                            lt_q    <= cmp_lt;
                        end else begin
                            ferr_q  <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign gt         = gt_q;
    assign eq         = eq_q;
    assign lt         = lt_q;
    assign busy       = state_q != ST_IDLE;
endmodule

// File: tb/tb_serial_parity_receiver.sv
// tb_serial_parity_receiver: directed plus random frames checked against a frame-level model
module tb_serial_parity_receiver;
    localparam int DATA_W     = 8;
    localparam bit PARITY_ODD = 1'b0;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              bit_en = 1'b0;
    logic              sin = 1'b1;
    logic [DATA_W-1:0] ref_word = '0;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              gt;
    logic              eq;
    logic              lt;
    logic              busy;
    int                checks = 0;
    int                errors = 0;
    int                gap = 0;
    bit                chk_low = 1'b0;
    logic [DATA_W-1:0] m_data = '0;
    logic              m_gt = 1'b0;
    logic              m_eq = 1'b0;
    logic              m_lt = 1'b0;
    always #5 clk = ~clk;
    serial_parity_receiver #(.DATA_W(DATA_W), .PARITY_ODD(PARITY_ODD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .sin        (sin),
        .ref_word   (ref_word),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .gt         (gt),
        .eq         (eq),
        .lt         (lt),
        .busy       (busy)
    );
    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask
    task automatic chk8(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic check_held();
        chk8("data_out", data_out, m_data);
        chk1("gt", gt, m_gt);
        chk1("eq", eq, m_eq);
        chk1("lt", lt, m_lt);
    endtask
    // one clk after a stop bit every pulse must be gone
    task automatic pulse_check();
        if (chk_low) begin
            chk1("valid_width", data_valid, 1'b0);
            chk1("perr_width", parity_err, 1'b0);
            chk1("ferr_width", frame_err, 1'b0);
            check_held();
            chk_low = 1'b0;
        end
    endtask
    task automatic send_bit(input logic b);
        repeat (gap) begin
            @(negedge clk);
            bit_en = 1'b0;
            @(posedge clk);
            #1;
            pulse_check();
        end
        @(negedge clk);
        sin = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        pulse_check();
    endtask
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s, input logic [DATA_W-1:0] r);
        int ones;
        logic exp_perr;
        ref_word = r;
        send_bit(1'b0);
        chk1("busy_in_frame", busy, 1'b1);
        for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
        ones = $countones(d) + int'(p);
        exp_perr = s && ((ones % 2) != int'(PARITY_ODD));
        if (s) begin
            m_data = d;
            m_gt = d > r;
            m_eq = d == r;
            m_lt = d < r;
        end
        chk1("data_valid", data_valid, s);
        chk1("parity_err", parity_err, exp_perr);
        chk1("frame_err", frame_err, !s);
        chk1("busy_after_stop", busy, 1'b0);
        check_held();
        ref_word = DATA_W'($urandom);
        chk_low = 1'b1;
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bit_en = 1'b0;
        sin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_data = '0;
        m_gt = 1'b0;
        m_eq = 1'b0;
        m_lt = 1'b0;
        chk_low = 1'b0;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_valid", data_valid, 1'b0);
        chk1("rst_perr", parity_err, 1'b0);
        chk1("rst_ferr", frame_err, 1'b0);
        check_held();
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    initial begin
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] r;
        logic              p;
        logic              s;
        do_reset();
        gap = 0;
        repeat (20) send_bit(1'b1);
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_valid", data_valid, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 8'h80);
        send_frame(8'h3C, 1'b1, 1'b1, 8'h3C);
        send_frame(8'h11, 1'b0, 1'b0, 8'h11);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        chk1("partial_busy", busy, 1'b1);
        do_reset();
        send_frame(8'h01, 1'b0, 1'b1, 8'h02);
        gap = 2;
        send_frame(8'hFF, 1'b0, 1'b1, 8'h10);
        send_frame(8'h00, 1'b0, 1'b1, 8'h10);
        for (int n = 0; n < 40; n++) begin
            gap = $urandom_range(0, 3);
            d = DATA_W'($urandom);
            p = 1'($urandom);
            s = $urandom_range(0, 4) != 0;
            r = ($urandom_range(0, 3) == 0) ? d : DATA_W'($urandom);
            repeat ($urandom_range(0, 2)) send_bit(1'b1);
            send_frame(d, p, s, r);
        end
        gap = 0;
        send_bit(1'b1);
        chk1("final_busy", busy, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
